// File: rtl/piso_pkg.sv
// piso_tx shared types and frame sizing helpers.
// Optional parity bit enabled by defining PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int frame_len(input int w);
`ifdef PISO_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(frame_len(w) + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/piso_shreg.sv
// Loadable right-shift register, zero fill at MSB.
// Async active-low clear; load wins over shift.
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, valid/ready input.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  state_t state, state_nx;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic sout_nx, sval_nx;
  logic at_last, accept;
  logic load, shift;
  logic go_shift, go_stop;
  logic nxt_bit, sh_lsb;
  logic [WIDTH-1:0] sh_d;

  assign at_last  = (bit_cnt == LAST);
  assign in_ready = (state == IDLE) ||
                    (state == SHIFT && at_last);
  assign accept   = in_valid && in_ready;
  assign go_shift = (state == SHIFT) && !at_last;
  assign go_stop  = (state == SHIFT) && at_last &&
                    !in_valid;
  assign s_last   = s_valid && at_last;
  assign busy     = s_valid;

  // bit 0 leaves directly from p_in, so the register holds the rest
  assign sh_d = p_in >> 1;

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(shift),
    .d    (sh_d),
    .lsb  (sh_lsb)
  );

`ifdef PISO_PARITY_EN
  logic parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^p_in;
    end
  end

  assign nxt_bit = (bit_cnt == CW'(WIDTH - 1)) ?
                   parity : sh_lsb;
`else
  assign nxt_bit = sh_lsb;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    sout_nx  = s_out;
    sval_nx  = s_valid;
    load     = 1'b0;
    shift    = 1'b0;
    unique case (1'b1)
      accept: begin
        state_nx = SHIFT;
        cnt_nx   = '0;
        sout_nx  = p_in[0];
        sval_nx  = 1'b1;
        load     = 1'b1;
      end
      go_shift: begin
        cnt_nx  = bit_cnt + 1'b1;
        sout_nx = nxt_bit;
        shift   = 1'b1;
      end
      go_stop: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        sout_nx  = 1'b0;
        sval_nx  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      s_out   <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      s_out   <= sout_nx;
      s_valid <= sval_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx at WIDTH=4 and WIDTH=8.
// Build with or without PISO_PARITY_EN.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F4 = 4 + PAR;
  localparam int F8 = 8 + PAR;

  logic clk, rst_n;
  logic [3:0] p4;
  logic v4, r4, so4, sv4, sl4, b4;
  logic [7:0] p8;
  logic v8, r8, so8, sv8, sl8, b8;

  int checks = 0;
  int failures = 0;

  piso_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .p_in(p4),
    .in_valid(v4), .in_ready(r4), .s_out(so4),
    .s_valid(sv4), .s_last(sl4), .busy(b4)
  );

  piso_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .p_in(p8),
    .in_valid(v8), .in_ready(r8), .s_out(so8),
    .s_valid(sv8), .s_last(sl8), .busy(b8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // model: queue of pending line bits {last, bit}; front is on the line
  logic [1:0] q4[$];
  logic [1:0] q8[$];
  logic [7:0] sent8[$];

  always @(posedge clk or negedge rst_n) begin : mdl
    bit a4;
    bit a8;
    if (!rst_n) begin
      q4.delete();
      q8.delete();
      sent8.delete();
    end else begin
      a4 = v4 && (q4.size() <= 1);
      a8 = v8 && (q8.size() <= 1);
      if (q4.size() > 0) void'(q4.pop_front());
      if (q8.size() > 0) void'(q8.pop_front());
      if (a4)
        for (int i = 0; i < F4; i++)
          q4.push_back({i == F4 - 1,
                        (i < 4) ? p4[i] : ^p4});
      if (a8) begin
        sent8.push_back(p8);
        for (int i = 0; i < F8; i++)
          q8.push_back({i == F8 - 1,
                        (i < 8) ? p8[i] : ^p8});
      end
    end
  end

  // loopback SIPO on the 4-bit line
  logic [3:0] sipo = '0;
  always @(posedge clk)
    if (sv4) sipo <= {so4, sipo[3:1]};

  int bp8 = 0;
  int words8 = 0;
  logic [7:0] acc8 = '0;

  always @(negedge clk) begin : cmp
    logic [7:0] w;
    chk("d4_valid", sv4, q4.size() > 0);
    chk("d4_out", so4,
        q4.size() > 0 ? q4[0][0] : 1'b0);
    chk("d4_last", sl4,
        q4.size() > 0 ? q4[0][1] : 1'b0);
    chk("d4_busy", b4, q4.size() > 0);
    chk("d4_ready", r4, q4.size() <= 1);
    chk("d8_valid", sv8, q8.size() > 0);
    chk("d8_out", so8,
        q8.size() > 0 ? q8[0][0] : 1'b0);
    chk("d8_last", sl8,
        q8.size() > 0 ? q8[0][1] : 1'b0);
    chk("d8_busy", b8, q8.size() > 0);
    chk("d8_ready", r8, q8.size() <= 1);
    if (!rst_n) begin
      bp8 = 0;
    end else if (sv8) begin
      if (bp8 < 8) acc8[bp8] = so8;
      bp8++;
      if (sl8) begin
        chk("d8_len", bp8, F8);
        chk("d8_sent", sent8.size() > 0, 1);
        if (sent8.size() > 0) begin
          w = sent8.pop_front();
          chk("d8_word", acc8, w);
          if (PAR == 1) chk("d8_par", so8, ^w);
        end
        words8++;
        bp8 = 0;
      end
    end
  end

  task automatic send4(input logic [3:0] w,
                       output logic [9:0] b);
    p4 = w;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    b = '0;
    for (int i = 0; i < F4; i++) begin
      b[i] = so4;
      @(negedge clk);
    end
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [4:0] e1;
    logic [9:0] got, e2, bits;
    logic [3:0] w3;
    clk = 1'b0;
    rst_n = 1'b0;
    v4 = 1'b0; p4 = '0;
    v8 = 1'b0; p8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", r4, 1);
    chk("rst_sval", sv4, 0);
    chk("rst_busy", b4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word 1011
    e1 = (PAR == 1) ? 5'b11011 : 5'b01011;
    p4 = 4'b1011;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    for (int i = 0; i < F4; i++) begin
      chk($sformatf("t1_bit%0d", i), so4, e1[i]);
      chk($sformatf("t1_last%0d", i), sl4,
          i == F4 - 1);
      @(negedge clk);
    end
    chk("t1_busy_end", b4, 0);
`ifndef PISO_PARITY_EN
    chk("t1_sipo", sipo, 4'b1011);
`endif

    // back-to-back A then 5
    e2 = (PAR == 1) ? 10'b0010101010 : 10'b0001011010;
    got = '0;
    p4 = 4'hA;
    v4 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 * F4; i++) begin
      got[i] = so4;
      chk($sformatf("t2_sv%0d", i), sv4, 1);
      if (i == 0) begin
        chk("t2_rdy_first", r4, 0);
        p4 = 4'h5;
      end
      if (i == F4 - 1) chk("t2_rdy_last", r4, 1);
      if (i == F4) v4 = 1'b0;
      @(negedge clk);
    end
    chk("t2_serial", got, e2);
    chk("t2_idle", sv4, 0);

    // hold-off: p_in churns while in_ready is low
    p4 = 4'h9;
    v4 = 1'b1;
    @(negedge clk);
    w3 = '0;
    for (int j = 0; j < F4; j++) begin
      if (j < 4) w3[j] = so4;
      if (j < 3) begin
        chk($sformatf("t3_rdy%0d", j), r4, 0);
        p4 = 4'($urandom);
      end else begin
        v4 = 1'b0;
      end
      @(negedge clk);
    end
    chk("t3_word", w3, 4'h9);

    // async reset during bit 2
    p4 = 4'hC;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre", so4, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_sout", so4, 0);
    chk("t4_rst_sval", sv4, 0);
    chk("t4_rst_busy", b4, 0);
    chk("t4_rst_last", sl4, 0);
    chk("t4_rst_ready", r4, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ready", r4, 1);
    send4(4'h6, bits);
    chk("t4_clean", bits[3:0], 4'h6);

`ifdef PISO_PARITY_EN
    send4(4'b0111, bits);
    chk("t5_bits", bits[4:0], 5'b10111);
    send4(4'b0011, bits);
    chk("t5_par0", bits[4], 0);
    chk("t5_data", bits[3:0], 4'b0011);
`endif

    // 8-bit random traffic with gaps
    for (int c = 0; c < 300; c++) begin
      v8 = ($urandom_range(0, 2) != 0);
      p8 = 8'($urandom);
      @(negedge clk);
    end
    v8 = 1'b0;
    repeat (F8 + 2) @(negedge clk);
    chk("t6_words", words8 > 10, 1);
    chk("t6_drained", sent8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
